// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: cache miss fill sequencer.
// Issues one read per word of a block and steers returned words into the cache.
module cache_fill_fsm #(
    parameter int WORDS_PER_BLOCK = 8,
    localparam int IW = $clog2(WORDS_PER_BLOCK)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          miss_detected,
    input  logic [15:0]   miss_address,
    input  logic [15:0]   memory_data,
    input  logic          memory_data_valid,
    output logic          fsm_busy,
    output logic          memory_read,
    output logic [15:0]   memory_address,
    output logic          write_data_array,
    output logic          write_tag_array,
    output logic [IW-1:0] word_index,
    output logic [15:0]   fill_data,
    output logic [15:0]   fill_base
);

    // Reject block sizes that are not a power of two or smaller than two words.
    if ((WORDS_PER_BLOCK < 2) ||
        ((WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0) ||
        (IW + 2 > 16)) begin : g_bad_param
        $error("cache_fill_fsm: WORDS_PER_BLOCK must be a power of 2, >= 2");
    end

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_t;

    // Byte offset mask within a block (block is 2 bytes per word).
    localparam logic [15:0]   LP_OFS_MASK = 16'(2 * WORDS_PER_BLOCK - 1);
    localparam logic [IW:0]   LP_WORDS    = (IW + 1)'(WORDS_PER_BLOCK);
    localparam logic [IW-1:0] LP_LAST     = IW'(WORDS_PER_BLOCK - 1);

    state_t        r_state;
    state_t        w_next_state;
    logic [IW:0]   r_issue_cnt;
    logic [IW-1:0] r_recv_cnt;
    logic [15:0]   r_fill_base;

    logic          w_miss_accept;
    logic          w_issue_active;
    logic          w_recv;
    logic          w_last;
    logic [15:0]   w_miss_base;
    logic [15:0]   w_issue_offset;

    // A miss is only honoured while idle; FILL ignores the request lines.
    assign w_miss_accept  = (r_state == ST_IDLE) && miss_detected;
    assign w_issue_active = (r_state == ST_FILL) && (r_issue_cnt < LP_WORDS);
    assign w_recv         = (r_state == ST_FILL) && memory_data_valid;
    assign w_last         = w_recv && (r_recv_cnt == LP_LAST);
    assign w_miss_base    = miss_address & ~LP_OFS_MASK;
    assign w_issue_offset = 16'({r_issue_cnt, 1'b0});

    // State register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: leave FILL only on the final returned word.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (miss_detected) begin
                    w_next_state = ST_FILL;
                end
            end
            ST_FILL: begin
                if (w_last) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Block base latch plus independent request and return counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fill_base <= '0;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
        end else if (w_miss_accept) begin
            r_fill_base <= w_miss_base;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
        end else begin
            if (w_issue_active) begin
                r_issue_cnt <= r_issue_cnt + 1'b1;
            end
            if (w_recv) begin
                r_recv_cnt <= r_recv_cnt + 1'b1;
            end
        end
    end

    // Output decode; everything but base and data is quiet outside FILL.
    always_comb begin
        fsm_busy         = (r_state == ST_FILL);
        memory_read      = w_issue_active;
        memory_address   = '0;
        write_data_array = w_recv;
        write_tag_array  = w_last;
        word_index       = '0;
        if (w_issue_active) begin
            memory_address = r_fill_base + w_issue_offset;
        end
        if (w_recv) begin
            word_index = r_recv_cnt;
        end
    end

    assign fill_data = memory_data;
    assign fill_base = r_fill_base;

endmodule

// File: doc/cache_fill_fsm.md
# cache_fill_fsm

Miss-handling controller between the CPU's fetch/memory stage and the multi-cycle main memory. When the cache signals a miss, this block sequences one read request per word of the 8-word block from main memory, steers each returned word into the cache data array, and writes the tag on the final word. While a fill is in progress it holds `fsm_busy` high so the CPU can stall its PC and pipeline.

## Interface
**Parameters**
- `WORDS_PER_BLOCK`, default 8: words per cache block.
  - Must be a power of 2, at least 2.
  - Block size in bytes is 2×`WORDS_PER_BLOCK`.
  - Index width `IW` = log2(`WORDS_PER_BLOCK`).

**Ports**
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `miss_detected`  in  1  — cache miss request. Sampled only in IDLE.
- `miss_address`  in  16  — byte address of the missing access. Sampled together with `miss_detected`.
- `memory_data`  in  16  — word returned by main memory.
- `memory_data_valid`  in  1  — `memory_data` is valid this cycle.
- `fsm_busy`  out  1  — fill in progress; the CPU stalls while it is high.
- `memory_read`  out  1  — issue a read request to main memory this cycle.
- `memory_address`  out  16  — byte address of the request.
- `write_data_array`  out  1  — write `fill_data` into the cache data array this cycle.
- `write_tag_array`  out  1  — write the tag/valid for `fill_base` this cycle.
- `word_index`  out  `IW`  — word slot within the block being written.
- `fill_data`  out  16  — data to write. Combinational pass-through of `memory_data`.
- `fill_base`  out  16  — latched block base address.

## Operation
**States:** IDLE, FILL.

**IDLE**
- On a rising edge with `miss_detected`=1:
  - Latch `fill_base` = `miss_address` with its low log2(2×`WORDS_PER_BLOCK`) bits cleared (4 bits for the default).
  - Clear `issue_cnt` and `recv_cnt`.
  - Go to FILL.
- `memory_data_valid` in IDLE is ignored.
- All outputs except `fill_base` and `fill_data` are 0.

**FILL: request side**
- While `issue_cnt` < `WORDS_PER_BLOCK`:
  - `memory_read`=1.
  - `memory_address` = `fill_base` + 2×`issue_cnt`, modulo 2^16.
  - `issue_cnt` increments each cycle.
- After all requests are issued, `memory_read`=0 and `memory_address`=0.

**FILL: receive side (independent of the request side)**
- In every cycle with `memory_data_valid`=1:
  - `write_data_array`=1.
  - `word_index`=`recv_cnt`.
  - `recv_cnt` increments.
- On the valid where `recv_cnt`=`WORDS_PER_BLOCK`−1:
  - `write_tag_array`=1 in the same cycle.
  - Next state is IDLE.

**Other behaviour**
- `miss_detected` and `miss_address` are ignored during FILL; the latched base is not disturbed.
- Memory returns data in request order. Counting returned words is the only bookkeeping.
- `fsm_busy` = (state == FILL).

**Reset** (asynchronous, any time, including mid-fill):
- State goes to IDLE immediately.
- Counters, `fill_base`, and all registered outputs go to 0.
- Valids still in flight from the aborted fill are ignored, because the block is in IDLE.

## Timing
Cycle 0 is the cycle in which `miss_detected` is sampled. Default `WORDS_PER_BLOCK`=8, memory latency L.

- Cycles 1–8: `memory_read`=1, addresses base+0, +2, … +14.
- Returns arrive at cycles 1+L … 8+L. Each return gives a data write in the same cycle, with index 0..7.
- Cycle 8+L: last data write plus tag write.
- Cycle 9+L: IDLE, `fsm_busy`=0. A new miss may be accepted in this cycle.
- For L=4: `fsm_busy` is high in cycles 1–12 (12 cycles); the block is IDLE again at cycle 13.
- Zero-cycle turnaround: a miss held high continuously restarts the fill in the first IDLE cycle.
- Gaps in `memory_data_valid` stretch FILL. No timeout.
- Outputs after reset: `fsm_busy`=0, `memory_read`=0, `memory_address`=0, `write_data_array`=0, `write_tag_array`=0, `word_index`=0, `fill_base`=0.

## Test plan
- **Basic fill, L=4.** Miss at `miss_address`=0x1236.
  - `fill_base`=0x1230.
  - Reads to 0x1230..0x123E in cycles 1–8.
  - Return words 0xA000..0xA007 in cycles 5–12 give `word_index` 0..7 with matching `fill_data`.
  - `write_tag_array`=1 only in cycle 12; `fsm_busy` is low in cycle 13.
- **Wrap-around.** Miss at 0xFFFA.
  - Base 0xFFF0, addresses 0xFFF0..0xFFFE.
  - No carry into bit 16.
- **Stalled returns.** Drop `memory_data_valid` for 3 cycles between words 3 and 4.
  - `fsm_busy` stays high for 3 extra cycles.
  - Word indices stay contiguous.
  - Tag is written only with the 8th word.
- **Ignored inputs.** Pulse `miss_detected` with 0x4000 during FILL, and pulse `memory_data_valid` while IDLE.
  - `fill_base` is unchanged.
  - No writes occur from the IDLE valid.
- **Reset mid-fill.** Assert `rst` asynchronously after the 3rd return.
  - All outputs go to 0 immediately.
  - Later valids produce no writes.
  - A new miss at 0x0020 completes a full, correct fill.
- **Back-to-back misses.** Hold `miss_detected`=1 across the end of a fill.
  - The second fill starts in the first IDLE cycle.
  - `memory_read` is reasserted the following cycle.
